// File: rtl/conv_job_sequencer.sv
// Job controller for the convolution engine: load -> convolve -> unload, with
// exclusive shared-memory ownership, per-phase watchdog, abort and job status.
//
// state      | meaning
// IDLE       | no job, memory port unowned
// LOAD       | loader owns memory, waiting for load_done
// CONV_START | convolution owns memory, one-cycle start pulse
// CONV_WAIT  | convolution owns memory, waiting for conv_done rising edge
// UNLOAD     | unloader owns memory, waiting for unload_done
// DONE       | one-cycle completion pulse
// ERROR      | timeout or abort, held until the next start edge
module conv_job_sequencer #(
  parameter int                   TIMEOUT_W   = 20,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 20'hFFFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [7:0] image_addr_in_i,
  input  logic [2:0] kernel_sel_in_i,
  output logic [7:0] image_addr_o,
  output logic [2:0] kernel_sel_o,
  input  logic       load_done_i,
  input  logic       conv_done_i,
  input  logic       unload_done_i,
  output logic [1:0] mem_sel_o,
  output logic       conv_start_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  output logic [1:0] err_code_o,
  output logic [7:0] job_count_o
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] LOAD       = 3'd1;
  localparam logic [2:0] CONV_START = 3'd2;
  localparam logic [2:0] CONV_WAIT  = 3'd3;
  localparam logic [2:0] UNLOAD     = 3'd4;
  localparam logic [2:0] DONE       = 3'd5;
  localparam logic [2:0] ERROR      = 3'd6;

  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_MAX - 1'b1;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_LOAD   = 2'd1;
  localparam logic [1:0] ERR_CONV   = 2'd2;
  localparam logic [1:0] ERR_UNLOAD = 2'd3;

  logic [2:0]           state_q, state_d;
  logic                 start_prev_q, conv_prev_q;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [7:0]           image_addr_q, image_addr_d;
  logic [2:0]           kernel_sel_q, kernel_sel_d;
  logic [1:0]           err_code_q, err_code_d;
  logic [7:0]           job_count_q, job_count_d;
  logic [1:0]           mem_sel_q, mem_sel_d;
  logic                 conv_start_q, conv_start_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  logic start_edge, conv_edge, wd_expire, wait_state;

  assign start_edge = start_i & ~start_prev_q;
  assign conv_edge  = conv_done_i & ~conv_prev_q;
  assign wd_expire  = (wd_q == WD_LAST);
  assign wait_state = (state_q == LOAD) || (state_q == CONV_WAIT) || (state_q == UNLOAD);

  always_comb begin
    state_d      = state_q;
    image_addr_d = image_addr_q;
    kernel_sel_d = kernel_sel_q;
    err_code_d   = err_code_q;
    job_count_d  = job_count_q;
    case (state_q)
      IDLE, ERROR: begin
        // abort only matters once a job exists; in ERROR it just blocks restart
        if (start_edge && !(state_q == ERROR && abort_i)) begin
          state_d      = LOAD;
          image_addr_d = image_addr_in_i;
          kernel_sel_d = kernel_sel_in_i;
          err_code_d   = ERR_NONE;
        end
      end
      LOAD: begin
        if (abort_i) begin
          state_d    = ERROR;
          err_code_d = ERR_UNLOAD;
        end else if (load_done_i) begin
          state_d = CONV_START;
        end else if (wd_expire) begin
          state_d    = ERROR;
          err_code_d = ERR_LOAD;
        end
      end
      CONV_START: begin
        if (abort_i) begin
          state_d    = ERROR;
          err_code_d = ERR_UNLOAD;
        end else begin
          state_d = CONV_WAIT;
        end
      end
      CONV_WAIT: begin
        if (abort_i) begin
          state_d    = ERROR;
          err_code_d = ERR_UNLOAD;
        end else if (conv_edge) begin
          state_d = UNLOAD;
        end else if (wd_expire) begin
          state_d    = ERROR;
          err_code_d = ERR_CONV;
        end
      end
      UNLOAD: begin
        if (abort_i) begin
          state_d    = ERROR;
          err_code_d = ERR_UNLOAD;
        end else if (unload_done_i) begin
          state_d = DONE;
        end else if (wd_expire) begin
          state_d    = ERROR;
          err_code_d = ERR_UNLOAD;
        end
      end
      DONE: begin
        // the job is only counted once it leaves DONE without an abort
        if (abort_i) begin
          state_d    = ERROR;
          err_code_d = ERR_UNLOAD;
        end else begin
          state_d     = IDLE;
          job_count_d = job_count_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wd_d = '0;
    if (wait_state && (state_d == state_q)) wd_d = wd_q + 1'b1;
  end

  // outputs are registered from the next state so they align with state_q
  always_comb begin
    mem_sel_d = 2'd0;
    case (state_d)
      LOAD:                  mem_sel_d = 2'd1;
      CONV_START, CONV_WAIT: mem_sel_d = 2'd2;
      UNLOAD:                mem_sel_d = 2'd3;
      default:               mem_sel_d = 2'd0;
    endcase
    conv_start_d = (state_d == CONV_START);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
    error_d      = (state_d == ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      conv_prev_q  <= 1'b0;
      wd_q         <= '0;
      image_addr_q <= 8'd0;
      kernel_sel_q <= 3'd0;
      err_code_q   <= ERR_NONE;
      job_count_q  <= 8'd0;
      mem_sel_q    <= 2'd0;
      conv_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_i;
      conv_prev_q  <= conv_done_i;
      wd_q         <= wd_d;
      image_addr_q <= image_addr_d;
      kernel_sel_q <= kernel_sel_d;
      err_code_q   <= err_code_d;
      job_count_q  <= job_count_d;
      mem_sel_q    <= mem_sel_d;
      conv_start_q <= conv_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign image_addr_o = image_addr_q;
  assign kernel_sel_o = kernel_sel_q;
  assign mem_sel_o    = mem_sel_q;
  assign conv_start_o = conv_start_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign err_code_o   = err_code_q;
  assign job_count_o  = job_count_q;

endmodule

// File: doc/conv_job_sequencer.md
# conv_job_sequencer

Top-level job controller for the convolution engine. Sequences one complete job (serial load of image into shared memory, convolution run, serial unload of results) and grants ownership of the single shared memory port to exactly one of loader, convolution container, or unloader at a time. Latches user configuration (image address, kernel select) at job start and holds it stable for the whole job. Provides per-phase watchdog timeouts, abort, and job status.

## Interface
Parameters:
- TIMEOUT_W, 20: width of the per-phase watchdog counter.
- TIMEOUT_MAX, 20'hFFFFF: cycles allowed in any wait phase before error.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- start  in  1  job request; rising edge (registered compare) accepted only in IDLE.
- abort  in  1  level; forces ERROR from any non-IDLE state.
- image_addr_in  in  8  user image base address.
- kernel_sel_in  in  3  user kernel select.
- image_addr  out  8  latched config to convolution container.
- kernel_sel  out  3  latched config to convolution container.
- load_done  in  1  loader finished (1-cycle pulse or level).
- conv_done  in  1  convolution container done flag (level).
- unload_done  in  1  unloader finished.
- mem_sel  out  2  memory port owner: 0 none, 1 loader, 2 convolution, 3 unloader.
- conv_start  out  1  1-cycle start pulse to convolution container.
- busy  out  1  high in any state except IDLE.
- done  out  1  1-cycle pulse on job completion.
- error  out  1  sticky; cleared on next accepted start.
- err_code  out  2  0 none, 1 load timeout, 2 conv timeout, 3 unload timeout or abort.
- job_count  out  8  completed jobs, wraps 255->0.

## Operation
- States: IDLE, LOAD, CONV_START, CONV_WAIT, UNLOAD, DONE, ERROR.
- IDLE: mem_sel=0. Start rising edge -> latch image_addr_in/kernel_sel_in, clear error/err_code, -> LOAD.
- LOAD: mem_sel=1. load_done=1 -> CONV_START.
- CONV_START: mem_sel=2, conv_start=1, exactly one cycle -> CONV_WAIT.
- CONV_WAIT: mem_sel=2. Accept conv_done only on rising edge (conv_done=1, previous-cycle conv_done=0); stale high level at entry is ignored. Edge -> UNLOAD.
- UNLOAD: mem_sel=3. unload_done=1 -> DONE.
- DONE: mem_sel=0, done=1, job_count+1, one cycle -> IDLE.
- ERROR: mem_sel=0, error=1; stays until start rising edge, which begins a new job (-> LOAD) directly.
- Watchdog: counter clears on every state change; increments in LOAD, CONV_WAIT, UNLOAD; when count reaches TIMEOUT_MAX -> ERROR with err_code per phase.
- Priority per cycle: abort > phase completion > timeout. Completion in the same cycle as timeout completes normally.
- start edges while busy are ignored (not queued). abort in IDLE ignored; abort in DONE: done still pulses? No: abort wins, -> ERROR, no done, no count.
- image_addr/kernel_sel change only at accepted start.

## Timing
- Reset (async assert): state IDLE, mem_sel=0, conv_start=0, busy=0, done=0, error=0, err_code=0, job_count=0, image_addr=0, kernel_sel=0, watchdog=0, edge registers=0.
- All outputs registered; no combinational input-to-output paths.
- start edge at cycle N sampled -> busy=1, mem_sel=1 at N+1.
- load_done at cycle M -> conv_start=1, mem_sel=2 at M+1; conv_start low at M+2.
- conv_done rising edge at K -> mem_sel=3 at K+1. unload_done at U -> done=1, mem_sel=0 at U+1; busy=0 at U+2.
- mem_sel never passes directly between two nonzero owners except loader->conv and conv->unloader transitions above (one-cycle boundaries, no overlap).
- Reset mid-job: immediate return to reset values; no done pulse.

## Test plan
- Nominal job: start edge, load_done after 10 cycles, conv_done edge after 50, unload_done after 10 -> mem_sel 1,2,3,0 sequence, one conv_start pulse, done pulse, job_count=1, config outputs equal inputs latched at start.
- Stale conv_done: conv_done held 1 before CONV_WAIT -> no advance until it drops and rises again.
- Timeout: TIMEOUT_MAX=16, no conv_done -> ERROR after 16 cycles in CONV_WAIT, err_code=2, mem_sel=0; next start clears error, job proceeds.
- Abort vs completion: abort and unload_done same cycle -> ERROR, err_code=3, no done, job_count unchanged.
- Start while busy: second start edge during LOAD and config inputs changed -> ignored, image_addr/kernel_sel unchanged.
- Reset mid-CONV_WAIT and job_count wrap: 256 jobs -> job_count=0; async rst_n low mid-job -> all outputs at reset values immediately.
